flex_sp_deserializer: RTL and testbench
=======================================

Name: flex_sp_deserializer

Overview:
Parametrised serial-to-parallel deserializer. Successor to the fixed 8-bit serial-in shift register used in the receive path.
- Adds a configurable word width and shift direction.
- Adds a bit counter with word framing and a holding register with a valid/ready handshake.
- Adds overrun detection and a synchronous abort.
- Sits between the bit-level receive logic (sync/decode) and the byte-level consumer (FIFO or RCU).

Parameters:
NUM_BITS, 8, data bits per word (2..32).
SHIFT_MSB, 0, 0 = first-received bit lands in word_data[0] (LSB-first line); 1 = first-received bit lands in word_data[NUM_BITS-1].
CNT_W, $clog2(NUM_BITS+1), width of bit_count (derived, do not override).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
serial_in  in  1  serial data bit, sampled when shift_enable=1.
shift_enable  in  1  one-cycle strobe per received bit.
clear  in  1  synchronous abort: discard the partial word.
word_ready  in  1  consumer accepts word_data this cycle.
word_data  out  NUM_BITS  completed word (holding register).
word_valid  out  1  holding register contains an unconsumed word.
overrun  out  1  sticky: a completed word was dropped.
bit_count  out  CNT_W  number of bits in the current partial word.
parity_err  out  1  parity error for the held word (see Optional Feature).

Behaviour:
- Reset (rst=1, asynchronous):
  - Shift register to all 1s (idle line); bit_count = 0.
  - word_data = 0, word_valid = 0, overrun = 0, parity_err = 0.
- Shift: on clk with shift_enable=1 and clear=0:
  - SHIFT_MSB=0: shift right, serial_in enters at bit NUM_BITS-1.
  - SHIFT_MSB=1: shift left, serial_in enters at bit 0.
  - bit_count increments.
- Completion: shift_enable=1 while bit_count = NUM_BITS-1 (last bit).
  - Same edge: the full word, including the current bit, is formed and bit_count wraps to 0.
  - Transfer: if the holding register is free, or is freed this cycle (word_valid & word_ready), word_data takes the word and word_valid = 1 after that edge. Latency is 1 clk from the last bit's strobe.
  - Drop: if the holding register is occupied and word_ready=0, the new word is discarded, word_data is unchanged, and overrun is set.
- Handshake: word_valid & word_ready on an edge with no completion drives word_valid to 0. word_data keeps its stale value. word_ready while word_valid=0 is ignored.
- Simultaneous accept and completion: the new word is loaded and word_valid stays 1. No overrun.
- clear=1:
  - Shift register to all 1s and bit_count to 0; overrun to 0.
  - Overrides shift_enable in the same cycle.
  - The holding register and word_valid are unaffected and the handshake still operates.
- shift_enable with no pending consumer and no clear: bits accumulate indefinitely. There is no timeout.
- rst asserted mid-word: everything is reset immediately. The partial word is lost and no word_valid is produced.

Optional Feature:
Macro DESER_PARITY_EN.
- Defined:
  - Each frame is NUM_BITS data bits followed by one even-parity bit. bit_count counts to NUM_BITS and wraps after the parity bit.
  - The parity bit is not stored in word_data.
  - parity_err = XOR of data bits and parity bit, registered alongside word_data. It follows the same transfer/drop rules and is cleared by reset only.
  - Completion latency: 1 clk after the parity strobe.
- Not defined:
  - Frames are NUM_BITS bits.
  - parity_err is tied to 0.

Test Plan:
1. NUM_BITS=8, SHIFT_MSB=0, word_ready=1. Strobe bits 1,0,1,0,0,1,0,1 -> one cycle after the 8th strobe: word_data=0xA5, word_valid=1 for 1 cycle, bit_count=0.
2. SHIFT_MSB=1. Strobe 1 then seven 0s -> word_data=0x80 (the same bit sequence gives 0x01 with SHIFT_MSB=0).
3. word_ready=0. Send 0x12, then 0x34 -> word_data stays 0x12, overrun=1. Pulse clear -> overrun=0, word_valid still 1. Assert word_ready -> word_valid=0.
4. Hold word 0x55, word_ready=0. Assert word_ready on the same cycle as the 8th strobe of 0xAA -> word_data=0xAA, word_valid=1, overrun=0.
5. After 5 strobes (bit_count=5): assert clear together with shift_enable -> bit_count=0, no word produced. Then 8 strobes of 0x0F -> word_data=0x0F.
6. After 3 strobes, assert rst asynchronously between edges -> all outputs at reset values immediately. With DESER_PARITY_EN, send 0x07 with parity 0 -> parity_err=1; with parity 1 -> parity_err=0.

Source files
------------

// File: rtl/flex_sp_deserializer.sv
// Serial-to-parallel deserializer: bit framing, one-word holding register with valid/ready, sticky overrun.
// Define DESER_PARITY_EN to add a trailing even-parity bit per frame and drive parity_err.
module flex_sp_deserializer #(
  parameter int NUM_BITS  = 8,
  parameter int SHIFT_MSB = 0,
  parameter int CNT_W     = $clog2(NUM_BITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                serial_in,
  input  logic                shift_enable,
  input  logic                clear,
  input  logic                word_ready,
  output logic [NUM_BITS-1:0] word_data,
  output logic                word_valid,
  output logic                overrun,
  output logic [CNT_W-1:0]    bit_count,
  output logic                parity_err
);

`ifdef DESER_PARITY_EN
  localparam int LAST_IDX = NUM_BITS;
`else
  localparam int LAST_IDX = NUM_BITS - 1;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_IDX);

  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_BITS-1:0] word_q, word_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;

  logic [NUM_BITS-1:0] shifted;
  logic [NUM_BITS-1:0] new_word;
  logic                strobe;
  logic                is_last;
  logic                complete;
  logic                accept;
  logic                load;
  logic                drop;
  logic                data_shift;

  always_comb begin
    if (SHIFT_MSB != 0) begin
      shifted = {shift_q[NUM_BITS-2:0], serial_in};
    end else begin
      shifted = {serial_in, shift_q[NUM_BITS-1:1]};
    end
  end

  assign strobe   = shift_enable & ~clear;
  assign is_last  = (cnt_q == LAST_CNT);
  assign complete = strobe & is_last;
  assign accept   = valid_q & word_ready;
  assign load     = complete & (~valid_q | word_ready);
  assign drop     = complete & valid_q & ~word_ready;

`ifdef DESER_PARITY_EN
  // The parity strobe completes the frame but is never shifted into the data word.
  logic perr_q, perr_d;
  logic new_perr;

  assign data_shift = strobe & ~is_last;
  assign new_word   = shift_q;
  assign new_perr   = (^shift_q) ^ serial_in;
`else
  assign data_shift = strobe;
  assign new_word   = shifted;
`endif

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (clear) begin
      shift_d = '1;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else if (strobe) begin
      if (data_shift) begin
        shift_d = shifted;
      end
      cnt_d = is_last ? '0 : cnt_q + CNT_W'(1);
    end

    if (load) begin
      word_d  = new_word;
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end

    if (drop) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '1;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef DESER_PARITY_EN
  always_comb begin
    perr_d = perr_q;
    if (load) begin
      perr_d = new_perr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign word_data  = word_q;
  assign word_valid = valid_q;
  assign overrun    = ovr_q;
  assign bit_count  = cnt_q;

endmodule

// File: tb/tb_flex_sp_deserializer.sv
// Directed stimulus against LSB-first and MSB-first instances; scoreboard queues checked by negedge monitors.
module tb_flex_sp_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b1;
  logic       shift_enable = 1'b0;
  logic       clear = 1'b0;
  logic       word_ready = 1'b0;

  logic [7:0] l_data, m_data;
  logic       l_valid, m_valid;
  logic       l_ovr, m_ovr;
  logic [3:0] l_cnt, m_cnt;
  logic       l_perr, m_perr;

  typedef struct {
    logic [7:0] d;
    logic       p;
  } exp_t;

  exp_t q_lsb[$];
  exp_t q_msb[$];

  int n_cmp = 0;
  int n_bad = 0;

  flex_sp_deserializer #(.NUM_BITS(8), .SHIFT_MSB(0)) dut_lsb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .shift_enable(shift_enable),
    .clear(clear), .word_ready(word_ready), .word_data(l_data), .word_valid(l_valid),
    .overrun(l_ovr), .bit_count(l_cnt), .parity_err(l_perr)
  );

  flex_sp_deserializer #(.NUM_BITS(8), .SHIFT_MSB(1)) dut_msb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .shift_enable(shift_enable),
    .clear(clear), .word_ready(word_ready), .word_data(m_data), .word_valid(m_valid),
    .overrun(m_ovr), .bit_count(m_cnt), .parity_err(m_perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Handshake happens on the next rising edge whenever valid & ready are seen here.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && l_valid && word_ready) begin
      if (q_lsb.size() == 0) begin
        chk("lsb_unexpected_word", {24'd0, l_data}, 32'hFFFF_FFFF);
      end else begin
        e = q_lsb.pop_front();
        chk("lsb_word", {24'd0, l_data}, {24'd0, e.d});
        chk("lsb_perr", {31'd0, l_perr}, {31'd0, e.p});
      end
    end
    if (!rst && m_valid && word_ready) begin
      if (q_msb.size() == 0) begin
        chk("msb_unexpected_word", {24'd0, m_data}, 32'hFFFF_FFFF);
      end else begin
        e = q_msb.pop_front();
        chk("msb_word", {24'd0, m_data}, {24'd0, e.d});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic last_prep(input logic [7:0] d, input logic perr_exp, input bit push, input bit rdy_last);
    exp_t e;
    if (rdy_last) word_ready = 1'b1;
    if (push) begin
      e.d = d;
      e.p = perr_exp;
      q_lsb.push_back(e);
      e.d = rev8(d);
      q_msb.push_back(e);
    end
  endtask

  // Sends d LSB-first; pbit is only transmitted when parity framing is enabled.
  task automatic send_word(input logic [7:0] d, input logic pbit, input bit push, input bit rdy_last);
    logic perr_exp;
`ifdef DESER_PARITY_EN
    perr_exp = (^d) ^ pbit;
`else
    perr_exp = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      shift_enable = 1'b1;
      serial_in    = d[i];
`ifndef DESER_PARITY_EN
      if (i == 7) last_prep(d, perr_exp, push, rdy_last);
`endif
      tick();
    end
`ifdef DESER_PARITY_EN
    shift_enable = 1'b1;
    serial_in    = pbit;
    last_prep(d, perr_exp, push, rdy_last);
    tick();
`endif
    shift_enable = 1'b0;
    serial_in    = 1'b1;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      shift_enable = 1'b1;
      serial_in    = 1'b1;
      tick();
    end
    shift_enable = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_data", {24'd0, l_data}, 32'd0);
    chk("rst_valid", {31'd0, l_valid}, 32'd0);
    chk("rst_ovr", {31'd0, l_ovr}, 32'd0);
    chk("rst_cnt", {28'd0, l_cnt}, 32'd0);
    chk("rst_perr", {31'd0, l_perr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 1: 0xA5 LSB-first with consumer always ready
    word_ready = 1'b1;
    send_word(8'hA5, ^8'hA5, 1'b1, 1'b0);
    chk("t1_valid", {31'd0, l_valid}, 32'd1);
    chk("t1_data", {24'd0, l_data}, 32'hA5);
    chk("t1_cnt", {28'd0, l_cnt}, 32'd0);
    tick();
    chk("t1_valid_drop", {31'd0, l_valid}, 32'd0);

    // 2: one then seven zeros, both shift directions
    send_word(8'h01, ^8'h01, 1'b1, 1'b0);
    chk("t2_lsb", {24'd0, l_data}, 32'h01);
    chk("t2_msb", {24'd0, m_data}, 32'h80);
    tick();

    // 3: overrun while held, clear, then consume
    word_ready = 1'b0;
    send_word(8'h12, ^8'h12, 1'b1, 1'b0);
    send_word(8'h34, ^8'h34, 1'b0, 1'b0);
    chk("t3_data_kept", {24'd0, l_data}, 32'h12);
    chk("t3_ovr", {31'd0, l_ovr}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t3_ovr_clr", {31'd0, l_ovr}, 32'd0);
    chk("t3_valid_hold", {31'd0, l_valid}, 32'd1);
    word_ready = 1'b1;
    tick();
    chk("t3_consumed", {31'd0, l_valid}, 32'd0);

    // 4: accept and completion on the same edge
    word_ready = 1'b0;
    send_word(8'h55, ^8'h55, 1'b1, 1'b0);
    chk("t4_held", {24'd0, l_data}, 32'h55);
    send_word(8'hAA, ^8'hAA, 1'b1, 1'b1);
    chk("t4_data", {24'd0, l_data}, 32'hAA);
    chk("t4_valid", {31'd0, l_valid}, 32'd1);
    chk("t4_ovr", {31'd0, l_ovr}, 32'd0);
    tick();
    chk("t4_consumed", {31'd0, l_valid}, 32'd0);

    // 5: clear beats a simultaneous strobe and discards the partial word
    strobes(5);
    chk("t5_cnt5", {28'd0, l_cnt}, 32'd5);
    shift_enable = 1'b1;
    clear        = 1'b1;
    tick();
    shift_enable = 1'b0;
    clear        = 1'b0;
    chk("t5_cnt0", {28'd0, l_cnt}, 32'd0);
    tick();
    chk("t5_no_word", {31'd0, l_valid}, 32'd0);
    send_word(8'h0F, ^8'h0F, 1'b1, 1'b0);
    chk("t5_data", {24'd0, l_data}, 32'h0F);
    tick();

    // 6: asynchronous reset mid-word with a held word and overrun pending
    word_ready = 1'b0;
    send_word(8'h3C, ^8'h3C, 1'b0, 1'b0);
    send_word(8'h99, ^8'h99, 1'b0, 1'b0);
    chk("t6_ovr_pre", {31'd0, l_ovr}, 32'd1);
    strobes(3);
    chk("t6_cnt3", {28'd0, l_cnt}, 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_data", {24'd0, l_data}, 32'd0);
    chk("t6_rst_valid", {31'd0, l_valid}, 32'd0);
    chk("t6_rst_ovr", {31'd0, l_ovr}, 32'd0);
    chk("t6_rst_cnt", {28'd0, l_cnt}, 32'd0);
    chk("t6_rst_perr", {31'd0, l_perr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    word_ready = 1'b1;
    send_word(8'hC3, ^8'hC3, 1'b1, 1'b0);
    chk("t6_after_rst", {24'd0, l_data}, 32'hC3);
    tick();

`ifdef DESER_PARITY_EN
    send_word(8'h07, 1'b0, 1'b1, 1'b0);
    chk("par_bad", {31'd0, l_perr}, 32'd1);
    chk("par_data", {24'd0, l_data}, 32'h07);
    tick();
    send_word(8'h07, 1'b1, 1'b1, 1'b0);
    chk("par_good", {31'd0, l_perr}, 32'd0);
    tick();
`endif

    repeat (3) tick();
    chk("lsb_queue_drained", q_lsb.size(), 32'd0);
    chk("msb_queue_drained", q_msb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
